// File: rtl/dft_pkg.sv
// Shared types and constants for the BIST pattern scheduler: FSM states, LFSR taps,
// lane seed masks and the all-zero lock-up replacement value.
package dft_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StApply,
    StCapture,
    StCompare,
    StDone
  } state_e;

  // Feedback taps shared by the stimulus lanes and the MISR
  localparam int unsigned LfsrTapA = 15;
  localparam int unsigned LfsrTapB = 13;
  localparam int unsigned LfsrTapC = 12;
  localparam int unsigned LfsrTapD = 10;

  localparam logic [15:0] LaneMask1  = 16'h5555;
  localparam logic [15:0] LaneMask2  = 16'hAAAA;
  localparam logic [15:0] LockupFix  = 16'h0001;

  // An all-zero LFSR state never leaves zero, so it is replaced at load time
  function automatic logic [15:0] lane_seed(input logic [15:0] v);
    return (v == 16'h0000) ? LockupFix : v;
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// One combinational step of the 16-bit Fibonacci LFSR used for each stimulus lane.
module lfsr16_step
  import dft_pkg::*;
(
  input  logic [15:0] x_i,
  output logic [15:0] x_o
);

  assign x_o = {x_i[14:0], x_i[LfsrTapA] ^ x_i[LfsrTapB] ^ x_i[LfsrTapC] ^ x_i[LfsrTapD]};

endmodule

// File: rtl/dft_bist_sched.sv
// BIST scheduler: drives four LFSR stimulus lanes, captures responses into a signature and
// compares it against a golden value. Define DFT_MISR_EN for a shifting MISR signature.
module dft_bist_sched
  import dft_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 30,
  parameter int unsigned PAT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] num_pat,
  input  logic [15:0]      seed,
  input  logic [15:0]      golden_sig,
  input  logic [15:0]      dut_y,
  output logic [15:0]      X0,
  output logic [15:0]      X1,
  output logic [15:0]      X2,
  output logic [15:0]      X3,
  output logic             busy,
  output logic             capture,
  output logic             done,
  output logic             pass,
  output logic [15:0]      sig,
  output logic [PAT_W-1:0] pat_idx
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0][15:0]       lane_q, lane_d, lane_step;
  logic [15:0]            sig_q, sig_d, sig_upd;
  logic [PAT_W-1:0]       idx_q, idx_d, idx_inc;
  logic [PAT_W-1:0]       num_q, num_d;
  logic [7:0]             settle_q, settle_d;
  logic                   pass_q, pass_d;
  logic                   done_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lfsr16_step u_step (
      .x_i(lane_q[i]),
      .x_o(lane_step[i])
    );
  end

`ifdef DFT_MISR_EN
  assign sig_upd = {sig_q[14:0],
                    sig_q[LfsrTapA] ^ sig_q[LfsrTapB] ^ sig_q[LfsrTapC] ^ sig_q[LfsrTapD]}
                   ^ dut_y;
`else
  assign sig_upd = sig_q ^ dut_y;
`endif

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    sig_d    = sig_q;
    idx_d    = idx_q;
    num_d    = num_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        lane_d[0] = lane_seed(seed);
        lane_d[1] = lane_seed(seed ^ LaneMask1);
        lane_d[2] = lane_seed(seed ^ LaneMask2);
        lane_d[3] = lane_seed(~seed);
        sig_d     = '0;
        idx_d     = '0;
        num_d     = num_pat;
        settle_d  = '0;
        pass_d    = 1'b0;
        state_d   = (num_pat == '0) ? StCompare : StApply;
      end
      StApply: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StCapture;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StCapture: begin
        sig_d   = sig_upd;
        idx_d   = idx_inc;
        lane_d  = lane_step;
        state_d = (idx_inc == num_q) ? StCompare : StApply;
      end
      StCompare: begin
        pass_d  = (sig_q == golden_sig);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      lane_q   <= '0;
      sig_q    <= '0;
      idx_q    <= '0;
      num_q    <= '0;
      settle_q <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      sig_q    <= sig_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      // Registered so the pulse lands one cycle after the DONE state
      done_q   <= (state_q == StDone);
    end
  end

  assign X0      = lane_q[0];
  assign X1      = lane_q[1];
  assign X2      = lane_q[2];
  assign X3      = lane_q[3];
  assign busy    = (state_q != StIdle);
  assign capture = (state_q == StCapture);
  assign done    = done_q;
  assign pass    = pass_q;
  assign sig     = sig_q;
  assign pat_idx = idx_q;

endmodule

// File: tb/tb_dft_bist_sched.sv
// Self-checking bench for dft_bist_sched against a behavioural signature model.
module tb_dft_bist_sched;

  localparam int S  = 30;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] num_pat = '0;
  logic [15:0]   seed = '0, golden_sig = '0, y_const = '0;
  logic          loop_en = 1'b0;
  logic [15:0]   dut_y;
  logic [15:0]   X0, X1, X2, X3, sig;
  logic          busy, capture, done, pass;
  logic [PW-1:0] pat_idx;

  int n_checks = 0;
  int n_fail   = 0;

  assign dut_y = loop_en ? X0 : y_const;

  dft_bist_sched #(.SETTLE_CYCLES(S), .PAT_W(PW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_pat(num_pat), .seed(seed),
    .golden_sig(golden_sig), .dut_y(dut_y), .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .busy(busy), .capture(capture), .done(done), .pass(pass), .sig(sig), .pat_idx(pat_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: LFSR as shift plus parity of tapped bits (mask 0xB400)
  function automatic logic [15:0] m_step(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  function automatic logic [15:0] m_fix(input logic [15:0] v);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] m_upd(input logic [15:0] s, input logic [15:0] y);
`ifdef DFT_MISR_EN
    return m_step(s) ^ y;
`else
    return s ^ y;
`endif
  endfunction

  function automatic logic [15:0] m_sig(input logic [15:0] sd, input int n, input logic lp,
                                        input logic [15:0] yc);
    logic [15:0] x, acc;
    x = m_fix(sd);
    acc = '0;
    for (int k = 0; k < n; k++) begin
      acc = m_upd(acc, lp ? x : yc);
      x = m_step(x);
    end
    return acc;
  endfunction

  function automatic int m_lat(input int n);
    return n * (S + 1) + 3;
  endfunction

  // Drives one run from IDLE and records what happened; comparisons live in the scenarios
  task automatic do_run(input logic [15:0] s, input logic [PW-1:0] n, input logic [15:0] g,
                        input logic hold, output int dcyc, output int ccnt, output int fcap,
                        output logic [3:0][15:0] lanes);
    seed = s; num_pat = n; golden_sig = g; start = 1'b1;
    dcyc = -1; ccnt = 0; fcap = -1; lanes = '0;
    tick;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      tick;
      if (c == 1) lanes = {X3, X2, X1, X0};
      if (capture) begin
        ccnt++;
        if (fcap < 0) fcap = c;
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1;
    repeat (3) tick;
    n_checks++; if ({busy, capture, done, pass} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b want=0000", {busy, capture, done, pass}); end
    n_checks++; if ({X0, X1, X2, X3} !== 64'h0) begin n_fail++;
      $display("FAIL reset_lanes got=%h want=0", {X0, X1, X2, X3}); end
    n_checks++; if ({sig, pat_idx} !== '0) begin n_fail++;
      $display("FAIL reset_sig_idx got=%h/%0d want=0/0", sig, pat_idx); end
    start = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_zero_patterns;
    int d, cc, fc;
    logic [3:0][15:0] ln;
    loop_en = 1'b0; y_const = 16'h1234;
    do_run(16'h0BAD, '0, 16'h0000, 1'b0, d, cc, fc, ln);
    n_checks++; if (d !== 3) begin n_fail++; $display("FAIL zero_latency got=%0d want=3", d); end
    n_checks++; if (cc !== 0) begin n_fail++; $display("FAIL zero_capture got=%0d want=0", cc); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL zero_pass got=%b want=1", pass); end
    n_checks++; if (sig !== 16'h0) begin n_fail++; $display("FAIL zero_sig got=%h want=0", sig); end
  endtask

  task automatic test_single_pattern;
    int d, cc, fc;
    logic [3:0][15:0] ln;
    loop_en = 1'b0; y_const = 16'h0000;
    do_run(16'h0000, PW'(1), 16'h0000, 1'b0, d, cc, fc, ln);
    n_checks++; if (ln !== {16'hFFFF, 16'hAAAA, 16'h5555, 16'h0001}) begin n_fail++;
      $display("FAIL single_lanes got=%h want=ffffaaaa55550001", ln); end
    n_checks++; if (fc !== 31) begin n_fail++; $display("FAIL single_capture got=%0d want=31", fc); end
    n_checks++; if (d !== 34) begin n_fail++; $display("FAIL single_latency got=%0d want=34", d); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL single_pass got=%b want=1", pass); end
    n_checks++; if (pat_idx !== PW'(1)) begin n_fail++;
      $display("FAIL single_idx got=%0d want=1", pat_idx); end
  endtask

  task automatic test_loopback;
    int d, cc, fc;
    logic [3:0][15:0] ln;
    logic [15:0] exp;
    loop_en = 1'b1;
    exp = m_sig(16'hACE1, 4, 1'b1, 16'h0);
    do_run(16'hACE1, PW'(4), exp, 1'b0, d, cc, fc, ln);
    n_checks++; if (sig !== exp) begin n_fail++; $display("FAIL loop_sig got=%h want=%h", sig, exp); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL loop_pass got=%b want=1", pass); end
    n_checks++; if (d !== m_lat(4)) begin n_fail++;
      $display("FAIL loop_latency got=%0d want=%0d", d, m_lat(4)); end
    do_run(16'hACE1, PW'(4), exp ^ 16'h0001, 1'b0, d, cc, fc, ln);
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL loop_badgold got=%b want=0", pass); end
  endtask

  task automatic test_random;
    int d, cc, fc, n;
    logic [3:0][15:0] ln, el;
    logic [15:0] s, exp, g;
    logic flip;
    for (int it = 0; it < 6; it++) begin
      s = (it == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      n = $urandom_range(0, 6);
      loop_en = 1'($urandom_range(0, 1));
      y_const = 16'($urandom_range(0, 65535));
      exp = m_sig(s, n, loop_en, y_const);
      flip = 1'($urandom_range(0, 1));
      g = flip ? exp ^ 16'($urandom_range(1, 65535)) : exp;
      el = {m_fix(~s), m_fix(s ^ 16'hAAAA), m_fix(s ^ 16'h5555), m_fix(s)};
      do_run(s, PW'(n), g, 1'b0, d, cc, fc, ln);
      n_checks++; if (ln !== el) begin n_fail++;
        $display("FAIL rand_lanes it=%0d got=%h want=%h", it, ln, el); end
      n_checks++; if (sig !== exp) begin n_fail++;
        $display("FAIL rand_sig it=%0d got=%h want=%h", it, sig, exp); end
      n_checks++; if (pass !== !flip) begin n_fail++;
        $display("FAIL rand_pass it=%0d got=%b want=%b", it, pass, !flip); end
      n_checks++; if (d !== m_lat(n) || cc !== n) begin n_fail++;
        $display("FAIL rand_timing it=%0d got=%0d/%0d want=%0d/%0d", it, d, cc, m_lat(n), n); end
      n_checks++; if (pat_idx !== PW'(n)) begin n_fail++;
        $display("FAIL rand_idx it=%0d got=%0d want=%0d", it, pat_idx, n); end
    end
  endtask

  task automatic test_max_count;
    int d, cc, fc;
    logic [3:0][15:0] ln;
    logic [15:0] exp;
    loop_en = 1'b1;
    exp = m_sig(16'h1357, 15, 1'b1, 16'h0);
    do_run(16'h1357, PW'(15), exp, 1'b0, d, cc, fc, ln);
    n_checks++; if (d !== m_lat(15)) begin n_fail++;
      $display("FAIL max_latency got=%0d want=%0d", d, m_lat(15)); end
    n_checks++; if (sig !== exp || pass !== 1'b1) begin n_fail++;
      $display("FAIL max_sig got=%h/%b want=%h/1", sig, pass, exp); end
  endtask

  task automatic test_midrun_reset;
    int d, cc, fc;
    logic [3:0][15:0] ln;
    logic [15:0] exp;
    bit seen;
    loop_en = 1'b1;
    seed = 16'h4A4A; num_pat = PW'(3); golden_sig = 16'h0; start = 1'b1;
    tick;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick;
      if (pat_idx == PW'(1) && busy && !capture) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reach got=0 want=1"); end
    repeat (5) tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    n_checks++; if ({busy, capture, done, pass, sig, pat_idx, X0, X1, X2, X3} !== '0) begin
      n_fail++; $display("FAIL mid_reset got=%b%b%b%b %h %0d %h%h%h%h want=all zero",
        busy, capture, done, pass, sig, pat_idx, X0, X1, X2, X3); end
    exp = m_sig(16'h4A4A, 3, 1'b1, 16'h0);
    do_run(16'h4A4A, PW'(3), exp, 1'b0, d, cc, fc, ln);
    n_checks++; if (sig !== exp || pass !== 1'b1 || d !== m_lat(3)) begin n_fail++;
      $display("FAIL mid_rerun got=%h/%b/%0d want=%h/1/%0d", sig, pass, d, exp, m_lat(3)); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, cc1, cc2, fc;
    logic [3:0][15:0] ln;
    logic [15:0] exp, s1;
    loop_en = 1'b1;
    exp = m_sig(16'hBEEF, 2, 1'b1, 16'h0);
    do_run(16'hBEEF, PW'(2), exp, 1'b1, d1, cc1, fc, ln);
    s1 = sig;
    n_checks++; if (d1 !== m_lat(2) || cc1 !== 2) begin n_fail++;
      $display("FAIL b2b_first got=%0d/%0d want=%0d/2", d1, cc1, m_lat(2)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b want=0", busy); end
    do_run(16'hBEEF, PW'(2), exp, 1'b0, d2, cc2, fc, ln);
    n_checks++; if (d2 !== m_lat(2) || cc2 !== 2) begin n_fail++;
      $display("FAIL b2b_second got=%0d/%0d want=%0d/2", d2, cc2, m_lat(2)); end
    n_checks++; if (sig !== s1 || sig !== exp || pass !== 1'b1) begin n_fail++;
      $display("FAIL b2b_sig got=%h/%h/%b want=%h/%h/1", s1, sig, pass, exp, exp); end
  endtask

  initial begin
    test_reset;
    test_zero_patterns;
    test_single_pattern;
    test_loopback;
    test_random;
    test_max_count;
    test_midrun_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dft_bist_sched.md
DFT_BIST_SCHED -- requirements
Module: dft_bist_sched

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 30, hold cycles per pattern before capture (legal range 1..255).
REQ-002 SHALL have parameter PAT_W, default 16, width of the pattern count and index.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port start  in  1  level; sampled only in IDLE.
REQ-006 SHALL have port num_pat  in  PAT_W  number of patterns; sampled in LOAD.
REQ-007 SHALL have port seed  in  16  LFSR seed; sampled in LOAD.
REQ-008 SHALL have port golden_sig  in  16  expected signature; sampled in COMPARE.
REQ-009 SHALL have port dut_y  in  16  DUT response; sampled in CAPTURE.
REQ-010 SHALL have ports X0, X1, X2, X3  out  16 each  registered stimulus to the DUT.
REQ-011 SHALL have ports busy, capture, done, pass  out  1 each, sig  out  16, and pat_idx  out  PAT_W.

Function
REQ-012 SHALL implement the FSM IDLE, LOAD, APPLY, CAPTURE, COMPARE, DONE, with busy=1 in all states except IDLE.
REQ-013 SHALL go IDLE->LOAD on start=1; start SHALL be ignored in every other state.
REQ-014 LOAD (1 cycle) SHALL set X0=seed, X1=seed^16'h5555, X2=seed^16'hAAAA, X3=~seed, replace any lane value 0 with 16'h0001, clear sig, clear pat_idx, latch num_pat, and go to COMPARE if num_pat==0, else to APPLY.
REQ-015 APPLY SHALL hold X0..X3 for exactly SETTLE_CYCLES cycles via a settle counter, then go to CAPTURE.
REQ-016 CAPTURE (1 cycle) SHALL pulse capture=1, update sig with dut_y, increment pat_idx, and step all four lanes once.
REQ-017 CAPTURE SHALL go to COMPARE when the incremented pat_idx equals the latched num_pat, else to APPLY.
REQ-018 Each lane step SHALL be x' = {x[14:0], x[15]^x[13]^x[12]^x[10]}.
REQ-019 COMPARE (1 cycle) SHALL register pass = (sig==golden_sig).
REQ-020 DONE (1 cycle) SHALL pulse done=1, then go to IDLE; pass, sig and pat_idx SHALL hold until the next LOAD.
REQ-021 Latency SHALL be: done asserted N*(SETTLE_CYCLES+1)+3 cycles after the edge that samples start in IDLE (N=num_pat).
REQ-022 pat_idx SHALL wrap modulo 2^PAT_W; with num_pat = 2^PAT_W-1 the run SHALL terminate normally.

Reset
REQ-023 With rst=0 at a clock edge, the block SHALL go to IDLE and clear X0..X3, sig, pat_idx, settle counter, busy, capture, done and pass, including mid-run.
REQ-024 The first start SHALL be accepted on the first edge with rst=1.

Configuration
REQ-025 With DFT_MISR_EN defined, sig SHALL update as sig' = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ dut_y.
REQ-026 Without DFT_MISR_EN, sig SHALL update as sig' = sig ^ dut_y; ports and timing SHALL be identical in both builds.

Structure
REQ-027 A shared package dft_pkg SHALL hold the FSM state enum, the LFSR tap constants, the lane XOR masks 16'h5555/16'hAAAA, and the lock-up value 16'h0001.
REQ-028 The lane step SHALL be a sub-module lfsr16_step (combinational, 16 in / 16 out), instantiated four times; the MISR SHALL be inline.

Verification
REQ-029 num_pat=0, golden_sig=0, start pulse: done 3 cycles after start, pass=1, sig=0, no capture pulse.
REQ-030 num_pat=1, seed=0, dut_y=0: after LOAD, X0=0001, X1=5555, X2=AAAA, X3=FFFF; capture 31 cycles after start; done at cycle 34; pass=1 with golden_sig=0.
REQ-031 num_pat=4, seed=16'hACE1, dut_y=X0 loopback, golden from reference model: pass=1; with golden flipped in bit 0: pass=0; run in both DFT_MISR_EN builds.
REQ-032 rst=0 during APPLY of pattern 2: next cycle IDLE with all outputs 0; a new start gives a full fresh run with a matching signature.
REQ-033 start held high across the whole run: no restart while busy; a new run begins the cycle after DONE; back-to-back runs give an identical sig.
